four_bit_adder_core: RTL and testbench
======================================

// Module: four_bit_adder_core
// PURPOSE
//   4-bit two's-complement/unsigned adder with carry-in. Produces a 4-bit sum,
//   an unsigned carry-out and a signed overflow flag.
//   Ripple-carry datapath feeds a single output register stage, so results
//   appear one clock after operands are sampled.
//   Leaf arithmetic block for ALU-style datapaths in the arithmetic-circuits set.
// PARAMETERS
//   WIDTH  4  operand/sum width; fixed at 4 for this block; all checks assume 4
// PORTS
//   clk        in   1  single clock; all state updates on rising edge
//   rst        in   1  reset, synchronous, active-high
//   in_valid   in   1  operands x/y/carry_in valid this cycle
//   x          in   4  operand A
//   y          in   4  operand B
//   carry_in   in   1  carry into bit 0
//   sum        out  4  registered (x+y+carry_in)[3:0]
//   carry_out  out  1  registered carry out of bit 3
//   overflow   out  1  registered signed overflow
//   out_valid  out  1  sum/carry_out/overflow hold a fresh result
// BEHAVIOUR
//   - Reset: on a clk edge with rst=1: sum=4'b0000, carry_out=0, overflow=0,
//     out_valid=0. rst has priority over in_valid in the same cycle.
//   - Arithmetic: {carry_out,sum} == x + y + carry_in, evaluated as a 5-bit
//     unsigned sum. No truncation other than the 5-bit result.
//   - overflow = c3 ^ c4, where c3 = carry into bit 3 and c4 = carry_out.
//     Equivalently: x[3]==y[3] && sum[3]!=x[3].
//   - Latency 1: operands sampled at edge N with in_valid=1 give results
//     valid after edge N, with out_valid=1.
//   - in_valid=0 at an edge: out_valid<=0; sum/carry_out/overflow hold their
//     previous values. No back-pressure; a new operand set is accepted every
//     cycle.
//   - Datapath is a ripple chain: bit i sees carry c_i (c0 = carry_in) and
//     produces c_{i+1}.
//   - Boundaries:
//       1111+0001+0 wraps to sum=0000, carry_out=1.
//       1111+1111+1 gives sum=1111, carry_out=1.
//       0000+0000+0 gives all zeros.
//   - Reset asserted while a result is pending discards it; out_valid=0 on
//     the next cycle.
//   - No X propagation from unused state: every register has a reset value.
// STRUCTURE
//   - Shared package adder_pkg: localparam ADD_WIDTH=4; typedef
//     logic [ADD_WIDTH-1:0] nibble_t.
//   - Sub-module full_adder (a, b, cin -> s, cout), combinational:
//     s = a^b^cin, cout = a&b | cin&(a^b).
//     Instantiated 4 times in a generate loop.
//   - Top-level logic: carry chain, overflow XOR, output/valid register.
// TESTING
//   - 0101+0011+0, in_valid=1 -> next cycle sum=1000, carry_out=0,
//     overflow=1, out_valid=1
//   - 1111+0001+0 -> sum=0000, carry_out=1, overflow=0
//   - 1000+1000+0 -> sum=0000, carry_out=1, overflow=1
//   - 0111+0000+1 -> sum=1000, carry_out=0, overflow=1;
//     then 1111+1111+1 -> sum=1111, carry_out=1, overflow=0
//   - rst=1 together with in_valid=1 (0101+0101+0) -> next cycle all outputs
//     0, out_valid=0; then in_valid=0 -> out_valid stays 0, outputs hold
//   - Exhaustive sweep of 512 {x,y,carry_in}, one per cycle ->
//     each {carry_out,sum} == x+y+carry_in and overflow matches the sign rule

Source files
------------

// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared types and constants for the four_bit_adder_core slice.
//   ADD_WIDTH    : operand/sum width. The block only supports 4; the checks
//                  and the overflow tap position assume 4.
//   nibble_t     : one operand or sum word.
//   add_result_t : the registered result bundle (carry, overflow, sum).
// -----------------------------------------------------------------------------
package adder_pkg;

   localparam int ADD_WIDTH = 4;

   typedef logic [ADD_WIDTH-1:0] nibble_t;

   // Kept together so the output stage is a single register word that is
   // loaded or held as a unit.
   typedef struct packed {
      logic    carry_out;
      logic    overflow;
      nibble_t sum;
   } add_result_t;

   localparam add_result_t RESULT_RESET = '{carry_out: 1'b0, overflow: 1'b0, sum: '0};

endpackage : adder_pkg

// File: rtl/four_bit_adder_core_if.sv
// -----------------------------------------------------------------------------
// four_bit_adder_core_if
//   Operand/result bundle for four_bit_adder_core.
//   in_valid  : operands x/y/carry_in are valid this cycle
//   x, y      : 4-bit operands
//   carry_in  : carry into bit 0
//   sum       : registered (x+y+carry_in)[3:0]
//   carry_out : registered carry out of bit 3
//   overflow  : registered signed overflow
//   out_valid : result registers hold a fresh result
//   Modports: master drives operands (the producer), slave is the adder.
// -----------------------------------------------------------------------------
interface four_bit_adder_core_if;
   import adder_pkg::*;

   logic    in_valid;
   nibble_t x;
   nibble_t y;
   logic    carry_in;
   nibble_t sum;
   logic    carry_out;
   logic    overflow;
   logic    out_valid;

   modport master (
      output in_valid,
      output x,
      output y,
      output carry_in,
      input  sum,
      input  carry_out,
      input  overflow,
      input  out_valid
   );

   modport slave (
      input  in_valid,
      input  x,
      input  y,
      input  carry_in,
      output sum,
      output carry_out,
      output overflow,
      output out_valid
   );

endinterface : four_bit_adder_core_if

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   One-bit combinational full adder, the cell of the ripple chain.
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit  = a ^ b ^ cin
//   cout : carry out = a&b | cin&(a^b)
// -----------------------------------------------------------------------------
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic half_sum;

   // Propagate term is shared between the sum and the carry.
   assign half_sum = a ^ b;
   assign s        = half_sum ^ cin;
   assign cout     = (a & b) | (cin & half_sum);

endmodule : full_adder

// File: rtl/four_bit_adder_core.sv
// -----------------------------------------------------------------------------
// four_bit_adder_core
//   4-bit unsigned/two's-complement adder with carry-in. A ripple chain of
//   full_adder cells feeds one output register stage, so a result appears one
//   clock after its operands are sampled with in_valid=1.
//   clk : single clock, rising edge
//   rst : synchronous, active-high; wins over in_valid in the same cycle
//   bus : four_bit_adder_core_if.slave (operands in, registered result out)
//   When in_valid=0 at an edge, out_valid drops and the result registers hold.
// -----------------------------------------------------------------------------
module four_bit_adder_core
   import adder_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   four_bit_adder_core_if.slave   bus
);

   // carry_chain[i] is the carry into bit i; carry_chain[ADD_WIDTH] is c4.
   logic [ADD_WIDTH:0] carry_chain;
   nibble_t            sum_comb;
   logic               overflow_comb;

   add_result_t        result_reg;
   add_result_t        result_next;
   logic               out_valid_reg;
   logic               out_valid_next;

   assign carry_chain[0] = bus.carry_in;

   generate
      for (genvar gi = 0; gi < ADD_WIDTH; gi++) begin : g_bit
         full_adder u_fa (
            .a    (bus.x[gi]),
            .b    (bus.y[gi]),
            .cin  (carry_chain[gi]),
            .s    (sum_comb[gi]),
            .cout (carry_chain[gi+1])
         );
      end
   endgenerate

   // Signed overflow: carry into the sign bit disagrees with carry out of it.
   assign overflow_comb = carry_chain[ADD_WIDTH-1] ^ carry_chain[ADD_WIDTH];

   always_comb begin
      result_next    = result_reg;
      out_valid_next = bus.in_valid;
      if (bus.in_valid) begin
         result_next.sum       = sum_comb;
         result_next.carry_out = carry_chain[ADD_WIDTH];
         result_next.overflow  = overflow_comb;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result_reg    <= RESULT_RESET;
         out_valid_reg <= 1'b0;
      end else begin
         result_reg    <= result_next;
         out_valid_reg <= out_valid_next;
      end
   end

   assign bus.sum       = result_reg.sum;
   assign bus.carry_out = result_reg.carry_out;
   assign bus.overflow  = result_reg.overflow;
   assign bus.out_valid = out_valid_reg;

endmodule : four_bit_adder_core

// File: tb/tb_four_bit_adder_core.sv
module tb_four_bit_adder_core;
   import adder_pkg::*;

   logic clk = 1'b0;
   logic rst;

   four_bit_adder_core_if bus ();

   four_bit_adder_core dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic       rst;
      logic       in_valid;
      logic [3:0] x;
      logic [3:0] y;
      logic       cin;
      logic [3:0] exp_sum;
      logic       exp_cout;
      logic       exp_ovf;
      logic       exp_valid;
   } vec_t;

   // Reference state: last accepted result, kept as plain integers.
   logic [3:0] m_sum;
   logic       m_cout;
   logic       m_ovf;

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of stimulus, let the edge happen, sample 1 time unit later.
   task automatic step(input logic r, input logic v, input logic [3:0] a,
                       input logic [3:0] b, input logic c);
      rst          = r;
      bus.in_valid = v;
      bus.x        = a;
      bus.y        = b;
      bus.carry_in = c;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [3:0] s, input logic co,
                            input logic ov, input logic vld);
      check({tag, ".sum"},       {1'b0, bus.sum},         {1'b0, s});
      check({tag, ".carry_out"}, {4'b0, bus.carry_out},   {4'b0, co});
      check({tag, ".overflow"},  {4'b0, bus.overflow},    {4'b0, ov});
      check({tag, ".out_valid"}, {4'b0, bus.out_valid},   {4'b0, vld});
   endtask

   // Arithmetic model: integer sums, signed range test for overflow.
   task automatic model(input int a, input int b, input int c,
                        output logic [3:0] s, output logic co, output logic ov);
      int total, sa, sb, st;
      total = a + b + c;
      s     = 4'(total % 16);
      co    = (total >= 16);
      sa    = (a >= 8) ? a - 16 : a;
      sb    = (b >= 8) ? b - 16 : b;
      st    = sa + sb + c;
      ov    = (st > 7) || (st < -8);
   endtask

   vec_t table_v[7];

   initial begin
      logic [3:0] es;
      logic       ec, eo, v;
      logic [3:0] ra, rb;
      logic       rc;

      table_v[0] = '{1'b0, 1'b1, 4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b1};
      table_v[1] = '{1'b0, 1'b1, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1};
      table_v[2] = '{1'b0, 1'b1, 4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1};
      table_v[3] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1};
      table_v[4] = '{1'b0, 1'b1, 4'b0111, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b1, 1'b1};
      table_v[5] = '{1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1};
      // in_valid low: outputs hold the previous result, out_valid drops
      table_v[6] = '{1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0};

      // Reset state
      step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      check_all("reset", 4'h0, 1'b0, 1'b0, 1'b0);
      $display("reset: sum=%b cout=%b ovf=%b vld=%b", bus.sum, bus.carry_out, bus.overflow, bus.out_valid);

      // Directed table
      for (int i = 0; i < 7; i++) begin
         step(table_v[i].rst, table_v[i].in_valid, table_v[i].x, table_v[i].y, table_v[i].cin);
         check_all($sformatf("table%0d", i), table_v[i].exp_sum, table_v[i].exp_cout,
                   table_v[i].exp_ovf, table_v[i].exp_valid);
         $display("table%0d: %b+%b+%b vld=%b -> sum=%b cout=%b ovf=%b vld=%b", i,
                  table_v[i].x, table_v[i].y, table_v[i].cin, table_v[i].in_valid,
                  bus.sum, bus.carry_out, bus.overflow, bus.out_valid);
      end

      // Reset together with in_valid discards the pending operands
      step(1'b0, 1'b1, 4'b0011, 4'b0100, 1'b0);
      check_all("preload", 4'b0111, 1'b0, 1'b0, 1'b1);
      $display("preload: sum=%b vld=%b", bus.sum, bus.out_valid);
      step(1'b1, 1'b1, 4'b0101, 4'b0101, 1'b0);
      check_all("rst_with_valid", 4'b0000, 1'b0, 1'b0, 1'b0);
      $display("rst_with_valid: sum=%b vld=%b", bus.sum, bus.out_valid);
      step(1'b0, 1'b0, 4'b0101, 4'b0101, 1'b0);
      check_all("idle_after_rst", 4'b0000, 1'b0, 1'b0, 1'b0);
      $display("idle_after_rst: sum=%b vld=%b", bus.sum, bus.out_valid);

      // Exhaustive sweep, one operand set per cycle
      for (int i = 0; i < 512; i++) begin
         ra = 4'(i);
         rb = 4'(i >> 4);
         rc = 1'(i >> 8);
         step(1'b0, 1'b1, ra, rb, rc);
         model(int'(ra), int'(rb), int'(rc), es, ec, eo);
         check_all($sformatf("sweep%0d", i), es, ec, eo, 1'b1);
         $display("sweep%0d: %b+%b+%b -> sum=%b cout=%b ovf=%b", i, ra, rb, rc,
                  bus.sum, bus.carry_out, bus.overflow);
      end

      // Random stream with gaps; model holds the last accepted result
      model(15, 15, 1, m_sum, m_cout, m_ovf);
      for (int i = 0; i < 300; i++) begin
         ra = 4'($urandom_range(15));
         rb = 4'($urandom_range(15));
         rc = 1'($urandom_range(1));
         v  = ($urandom_range(3) != 0);
         step(1'b0, v, ra, rb, rc);
         if (v) model(int'(ra), int'(rb), int'(rc), m_sum, m_cout, m_ovf);
         check_all($sformatf("rand%0d", i), m_sum, m_cout, m_ovf, v);
         $display("rand%0d: %b+%b+%b vld=%b -> sum=%b cout=%b ovf=%b vld=%b", i, ra, rb, rc, v,
                  bus.sum, bus.carry_out, bus.overflow, bus.out_valid);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_four_bit_adder_core
